mem_byte_seq: RTL
=================

Name: mem_byte_seq

Overview:
- Load/store sequencer that sits between execute and the byte-wide data BRAM.
- Accepts one decoded RV32I memory op: base, offset and store data, plus funct3.
- Issues the op to the BRAM as sequential single-byte accesses. For loads, it assembles the bytes little-endian and sign- or zero-extends the result.
- Returns the result with a one-cycle done pulse. Downstream writeback consumes res/done.

Parameters:
ADDR_W, 10, byte address width to BRAM; all address arithmetic is mod 2^ADDR_W
BYTE_W, 8, BRAM data port width; fixed at 8, other values unsupported

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
op_mode1  input  2  00 load, 01 store, 10/11 illegal
op_mode2  input  3  funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; others illegal
op1  input  32  base (rs1)
op2  input  32  store data (rs2)
imm_data  input  32  offset
busy  output  1  high from start acceptance until done, inclusive
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = illegal op or trapped misalign
res  output  32  load result; valid with done, held until next accepted start
ram_addr  output  ADDR_W  BRAM byte address
ram_din  output  8  BRAM write byte
ram_en  output  1  BRAM enable
ram_we  output  1  BRAM write enable
ram_dout  input  8  BRAM read byte; valid exactly one cycle after ram_en && !ram_we

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, res=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- Reset mid-op: aborts immediately. No further BRAM access, no done pulse. Bytes already written remain.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - On start (cycle T), latch ea = (op1+imm_data)[ADDR_W-1:0], op2, and modes.
  - N = 1/2/4 bytes for funct3[1:0] = 00/01/10.
  - Legal op: go to ISSUE.
  - Illegal op_mode1 or funct3: go to FIN with err=1, no BRAM access.
- ISSUE: cycles T+1..T+N issue byte k=0..N-1.
  - ram_en=1, ram_addr=ea+k (wraps mod 2^ADDR_W), ram_we = store.
  - Store: ram_din = op2[8k+7:8k].
  - After the last byte: store goes to FIN; load goes to DRAIN.
- Load capture: ram_dout captured in the cycle after each issue into byte lane k. DRAIN covers the final byte's capture cycle; ram_en=0 there.
- FIN:
  - done=1, busy=1; next state IDLE.
  - Store: done in cycle T+N+1; res=0.
  - Load: done in cycle T+N+2; res = assembled value.
  - Error: done in cycle T+1; res=0, err=1.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW uses all 32 bits.
- start while busy (including the FIN cycle): ignored, no state effect.
- ram_en=0 and ram_we=0 in every cycle outside ISSUE; ram_addr/ram_din hold their last value.
- err=0 in every cycle with done=0.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with ea[0]=1, or LW/SW with ea[1:0]!=0, is treated as error. Goes to FIN at T+1, err=1, res=0, no BRAM access.
- Undefined: misaligned accesses proceed bytewise as normal, including address wrap past 2^ADDR_W-1 to 0.

Test Plan:
- SW op1=0x100, imm=0x4, op2=0xA1B2C3D4 at T -> writes addr 0x104..0x107 = D4,C3,B2,A1 in T+1..T+4; done at T+5, err=0, res=0.
- Then LW at ea=0x104 -> done at T+6 after start, res=0xA1B2C3D4. LB ea=0x107 -> res=0xFFFFFFA1; LBU ea=0x107 -> res=0x000000A1; LH ea=0x106 -> res=0xFFFFA1B2.
- LW op_mode2=011, or op_mode1=10 -> done at T+1, err=1, res=0, ram_en never asserted.
- SH at ea=0x3FF, op2=0x1234:
  - Macro undefined: 0x3FF=34, 0x000=12; done T+3.
  - Macro defined: err=1 at T+1, no write.
- start pulsed again at T+2 during an LW -> ignored; single done at T+6 with first op's data. rst at T+2 of an SW -> only 0x104,0x105 written, no done, busy=0 next cycle.
- Back-to-back: new start in the cycle after done -> accepted; busy stays low exactly one cycle between ops.

Source files
------------

// File: rtl/mem_byte_seq.sv
// mem_byte_seq
// Load/store sequencer between execute and a byte-wide data BRAM. One
// decoded RV32I memory op is accepted per start pulse. It is broken into
// 1, 2 or 4 single-byte BRAM accesses at consecutive addresses. For loads
// the bytes are assembled little-endian and then sign- or zero-extended.
// The op finishes with a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request pulse, only looked at while idle
//   op_mode1        00 load, 01 store, 1x illegal
//   op_mode2        funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   op1, imm_data   base and offset; byte address = (op1+imm_data) mod 2^ADDR_W
//   op2             store data
//   busy            op in flight, from the cycle after acceptance through done
//   done, err       completion pulse; err flags an illegal or trapped op
//   res             load result, held until the next accepted start
//   ram_addr, ram_din, ram_en, ram_we   BRAM request side
//   ram_dout        BRAM read byte, one cycle after a read enable
//
// Optional feature:
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                         finish immediately with err=1 instead of being
//                         issued bytewise.

module mem_byte_seq #(
  parameter int ADDR_W = 10,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op_mode1,
  input  logic [2:0]        op_mode2,
  input  logic [31:0]       op1,
  input  logic [31:0]       op2,
  input  logic [31:0]       imm_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       res,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_din,
  output logic              ram_en,
  output logic              ram_we,
  input  logic [BYTE_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t state, state_nxt;

  // Decode of the request presented with start
  logic [ADDR_W-1:0] ea;
  logic [1:0]        n_last_in;
  logic              legal_in;
  logic              misal_in;
  logic              go_issue;
  logic              accept;

  // Latched operation
  logic                    is_store_q;
  logic [2:0]              funct3_q;
  logic                    err_q;
  logic [1:0]              k_q;
  logic [1:0]              last_q;
  logic [3:0][BYTE_W-1:0]  store_q;

  // Load assembly
  logic [3:0][BYTE_W-1:0]  data_q;
  logic                    cap_vld_q;
  logic [1:0]              cap_idx_q;
  logic [3:0][BYTE_W-1:0]  full;
  logic [31:0]             ext;
  logic [31:0]             res_q;

  // Request decode: effective address, byte count and legality. The byte
  // count comes from funct3[1:0] alone; the 11 encoding is illegal anyway.
  always_comb begin
    ea        = ADDR_W'(op1 + imm_data);
    n_last_in = 2'd3;
    case (op_mode2[1:0])
      2'b00:   n_last_in = 2'd0;
      2'b01:   n_last_in = 2'd1;
      default: n_last_in = 2'd3;
    endcase
    legal_in = 1'b0;
    case (op_mode1)
      2'b00:   legal_in = (op_mode2[1:0] != 2'b11) && !(op_mode2[2] && op_mode2[1]);
      2'b01:   legal_in = !op_mode2[2] && (op_mode2[1:0] != 2'b11);
      default: legal_in = 1'b0;
    endcase
    misal_in = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misal_in = ((op_mode2[1:0] == 2'b01) && ea[0]) ||
               ((op_mode2[1:0] == 2'b10) && (ea[1:0] != 2'b00));
`endif
    go_issue = legal_in && !misal_in;
    accept   = (state == IDLE) && start;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the outputs that follow directly from the state.
  // Illegal or trapped requests skip straight to FIN so done comes one
  // cycle after acceptance without touching the BRAM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = go_issue ? ISSUE : FIN;
      ISSUE:   if (k_q == last_q) state_nxt = is_store_q ? FIN : DRAIN;
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy   = (state != IDLE);
    done   = (state == FIN);
    err    = (state == FIN) && err_q;
    ram_en = (state == ISSUE);
    ram_we = (state == ISSUE) && is_store_q;
    res    = res_q;
  end

  // Load result assembly. The byte arriving this cycle is merged in so the
  // final byte (captured during DRAIN) is already part of the value that
  // gets registered into res.
  always_comb begin
    full = data_q;
    if (cap_vld_q) full[cap_idx_q] = ram_dout;
    case (funct3_q)
      3'b000:  ext = {{24{full[0][BYTE_W-1]}}, full[0]};
      3'b001:  ext = {{16{full[1][BYTE_W-1]}}, full[1], full[0]};
      3'b100:  ext = {24'd0, full[0]};
      3'b101:  ext = {16'd0, full[1], full[0]};
      default: ext = full;
    endcase
  end

  // Datapath: latch the op on acceptance, step address/data through the
  // ISSUE cycles, and capture read bytes one cycle behind each read issue.
  // ram_addr/ram_din only move on acceptance of a legal op and between
  // bytes, so they hold their last value whenever the BRAM is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      err_q      <= 1'b0;
      k_q        <= 2'd0;
      last_q     <= 2'd0;
      store_q    <= '0;
      data_q     <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= 2'd0;
      res_q      <= 32'd0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      cap_vld_q <= ram_en && !ram_we;
      cap_idx_q <= k_q;
      if (cap_vld_q) data_q[cap_idx_q] <= ram_dout;

      if (accept) begin
        is_store_q <= op_mode1[0];
        funct3_q   <= op_mode2;
        last_q     <= n_last_in;
        k_q        <= 2'd0;
        err_q      <= !go_issue;
        store_q    <= op2;
        data_q     <= '0;
        res_q      <= 32'd0;
        if (go_issue) begin
          ram_addr <= ea;
          if (op_mode1[0]) ram_din <= op2[BYTE_W-1:0];
        end
      end

      if ((state == ISSUE) && (k_q != last_q)) begin
        k_q      <= k_q + 2'd1;
        ram_addr <= ram_addr + ADDR_W'(1);
        if (is_store_q) ram_din <= store_q[k_q + 2'd1];
      end

      if (state == DRAIN) res_q <= ext;
    end
  end

endmodule
